// File: rtl/uart_byte_transmitter_if.sv
// Byte handshake between the UART address decoder (master) and the
// transmit path (slave): DataIn is taken on an edge where
// DataInValid && DataInReady.
interface uart_byte_transmitter_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;

  modport master (
    output DataIn,
    output DataInValid,
    input  DataInReady
  );

  modport slave (
    input  DataIn,
    input  DataInValid,
    output DataInReady
  );
endinterface

// File: rtl/uart_byte_transmitter.sv
// UART byte transmitter: buffers bytes from the decoder in a small circular
// FIFO and serialises them onto SOut as asynchronous frames (start bit,
// 8 data bits LSB first, stop bit), back-to-back while bytes are queued.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
module uart_byte_transmitter #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  uart_byte_transmitter_if.slave        in_if,
  output logic                          SOut,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Level
);

  localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push;
  logic             pop;

  // Frame sequencer
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx;

  // Ready comes only from the registered level, so a pop on the same edge
  // never opens the FIFO early.
  assign in_if.DataInReady = (level_q != LVL_FULL);
  assign push              = in_if.DataInValid && in_if.DataInReady;

  assign SOut  = tx;
  assign Busy  = (state_q != IDLE) || (level_q != '0);
  assign Level = level_q;

  // Byte storage: written on accepted pushes, never reset
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr_q] <= in_if.DataIn;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Sequencer control state; reset aborts any frame and forces the line idle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // Shift data only matters while a frame is running, so it carries no reset
  always_ff @(posedge Clock) begin
    shreg_q <= shreg_d;
  end

  // Next-state, line level and pop decision for the frame sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    tx      = 1'b1;

    unique case (state_q)
      IDLE: begin
        tx = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q];
          cnt_d   = CNT_RELOAD;
          state_d = START;
        end
      end

      START: begin
        tx = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        tx = shreg_q[bit_q];
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = ^shreg_q;
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      STOP: begin
        tx = 1'b1;
        if (cnt_q == '0) begin
          // Chain straight into the next frame when a byte is waiting
          if (level_q != '0) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr_q];
            cnt_d   = CNT_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
